// File: rtl/cnn_pkg.sv
// Shared CNN constants and types used by the FC layer and its output stages.
// Holds class count, score width, argmax FSM states and the signed score type.
package cnn_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int SCORE_W     = 32;
  localparam int IDX_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } argmax_state_t;

  typedef logic signed [SCORE_W-1:0] score_t;

endpackage

// File: rtl/score_cmp.sv
// Signed strict-greater compare of a candidate against the running best.
// Ports: cand_val/cand_idx, best_val/best_idx in; new_val/new_idx/take out.
module score_cmp #(
  parameter int W  = cnn_pkg::SCORE_W,
  parameter int IW = cnn_pkg::IDX_W
) (
  input  logic [W-1:0]  cand_val,
  input  logic [IW-1:0] cand_idx,
  input  logic [W-1:0]  best_val,
  input  logic [IW-1:0] best_idx,
  output logic [W-1:0]  new_val,
  output logic [IW-1:0] new_idx,
  output logic          take
);

  // Strict > keeps the earlier (lower) index on ties.
  always_comb begin
    take    = $signed(cand_val) > $signed(best_val);
    new_val = take ? cand_val : best_val;
    new_idx = take ? cand_idx : best_idx;
  end

endmodule

// File: rtl/fc_argmax.sv
// Captures FC class scores on fc_done rise, scans one per clock for the max.
// Ports: clk, reset, fc_done, scores in; result_* handshake, busy, overrun.
module fc_argmax #(
  parameter int NUM_CLASSES = cnn_pkg::NUM_CLASSES,
  parameter int SCORE_W     = cnn_pkg::SCORE_W,
  parameter int IDX_W       = cnn_pkg::IDX_W
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                fc_done,
  input  logic [NUM_CLASSES-1:0][SCORE_W-1:0] scores,
  output logic                                result_valid,
  input  logic                                result_ready,
  output logic [IDX_W-1:0]                    class_idx,
  output logic [SCORE_W-1:0]                  max_score,
  output logic                                busy,
  output logic                                overrun
);

  import cnn_pkg::*;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

  argmax_state_t      state;
  logic               fc_done_q;
  logic               fc_rise;
  logic [IDX_W-1:0]   cnt;
  logic [SCORE_W-1:0] best_val;
  logic [IDX_W-1:0]   best_idx;
  logic [SCORE_W-1:0] bank [NUM_CLASSES];
  logic [SCORE_W-1:0] cand_val;
  logic [SCORE_W-1:0] nxt_val;
  logic [IDX_W-1:0]   nxt_idx;
  logic               take;

  // fc_done_q clears on reset, so a level already high at
  // release is seen as exactly one rising edge.
  assign fc_rise  = fc_done && !fc_done_q;
  assign cand_val = bank[cnt];

  score_cmp #(
    .W  (SCORE_W),
    .IW (IDX_W)
  ) u_cmp (
    .cand_val (cand_val),
    .cand_idx (cnt),
    .best_val (best_val),
    .best_idx (best_idx),
    .new_val  (nxt_val),
    .new_idx  (nxt_idx),
    .take     (take)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      fc_done_q    <= 1'b0;
      cnt          <= '0;
      best_val     <= '0;
      best_idx     <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      class_idx    <= '0;
      max_score    <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        bank[i] <= '0;
      end
    end else begin
      fc_done_q <= fc_done;
      unique case (state)
        IDLE: begin
          if (fc_rise) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
              bank[i] <= scores[i];
            end
            best_val <= scores[0];
            best_idx <= '0;
            cnt      <= IDX_W'(1);
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (fc_rise) begin
            overrun <= 1'b1;
          end
          best_val <= nxt_val;
          best_idx <= nxt_idx;
          cnt      <= cnt + 1'b1;
          // Last compare lands straight in the output registers.
          if (cnt == LAST) begin
            class_idx    <= nxt_idx;
            max_score    <= nxt_val;
            result_valid <= 1'b1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (fc_rise) begin
            overrun <= 1'b1;
          end
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax.sv
// Scoreboard bench for fc_argmax: expected argmax queued at capture,
// popped and compared when result_valid appears.
module tb_fc_argmax;

  localparam int N  = 10;
  localparam int W  = 32;
  localparam int IW = 4;

  typedef logic [N-1:0][W-1:0] frame_t;
  typedef struct {
    logic [IW-1:0] idx;
    logic [W-1:0]  val;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          fc_done;
  frame_t        scores;
  logic          result_valid;
  logic          result_ready;
  logic [IW-1:0] class_idx;
  logic [W-1:0]  max_score;
  logic          busy;
  logic          overrun;

  int   checks = 0;
  int   fails  = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  fc_argmax dut (
    .clk          (clk),
    .reset        (reset),
    .fc_done      (fc_done),
    .scores       (scores),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .class_idx    (class_idx),
    .max_score    (max_score),
    .busy         (busy),
    .overrun      (overrun)
  );

  function automatic exp_t model(input frame_t s);
    exp_t e;
    e.idx = '0;
    e.val = s[0];
    for (int i = 1; i < N; i++) begin
      if ($signed(s[i]) > $signed(e.val)) begin
        e.idx = IW'(i);
        e.val = s[i];
      end
    end
    return e;
  endfunction

  // Drive a rising fc_done at a negedge; returns at the negedge after E.
  task automatic fire(input frame_t s);
    scores  = s;
    fc_done = 1'b1;
    sbq.push_back(model(s));
    @(posedge clk);
    @(negedge clk);
  endtask

  // Counts negedges until result_valid, bounded at 40.
  task automatic wait_valid(output int n);
    n = 0;
    while (!result_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic exp_t pop_exp();
    exp_t e;
    e.idx = '0;
    e.val = '0;
    if (sbq.size() > 0) e = sbq.pop_front();
    return e;
  endfunction

  task automatic test_reset;
    reset        = 1'b1;
    fc_done      = 1'b0;
    result_ready = 1'b0;
    scores       = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 ||
        class_idx !== '0 || max_score !== '0) begin
      fails++;
      $display("FAIL reset_state: valid=%b busy=%b ovr=%b idx=%0d max=%h, want all 0",
               result_valid, busy, overrun, class_idx, max_score);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b valid=%b, want 0 0", busy, result_valid);
    end
  endtask

  task automatic test_basic;
    frame_t s;
    int     v [N] = '{5, 1, 2, 3, 4, 9, 0, 7, 8, 6};
    int     n;
    int     busy_low;
    exp_t   e;
    for (int i = 0; i < N; i++) s[i] = W'(v[i]);
    fire(s);
    fc_done = 1'b0;
    checks++;
    if (busy !== 1'b1 || result_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_busy_at_E: busy=%b valid=%b, want 1 0", busy, result_valid);
    end
    busy_low = 0;
    n = 0;
    while (!result_valid && n < 40) begin
      @(negedge clk);
      n++;
      if (busy !== 1'b1) busy_low++;
    end
    checks++;
    if (n !== 9) begin
      fails++;
      $display("FAIL basic_latency: got %0d edges, want 9", n);
    end
    checks++;
    if (busy_low !== 0) begin
      fails++;
      $display("FAIL basic_busy_scan: busy low %0d cycles, want 0", busy_low);
    end
    e = pop_exp();
    checks++;
    if (class_idx !== e.idx || max_score !== e.val) begin
      fails++;
      $display("FAIL basic_result: idx=%0d max=%0d, want idx=%0d max=%0d",
               class_idx, max_score, e.idx, e.val);
    end
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_ready = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || class_idx !== e.idx) begin
      fails++;
      $display("FAIL basic_xfer: valid=%b busy=%b idx=%0d, want 0 0 %0d",
               result_valid, busy, class_idx, e.idx);
    end
  endtask

  task automatic test_patterns;
    frame_t f [3];
    exp_t   e;
    int     n;
    for (int i = 0; i < N; i++) begin
      f[0][i] = -32'sd100;
      f[1][i] = 32'd7;
      f[2][i] = '0;
    end
    f[0][3] = 32'hFFFF_FFFF;
    f[2][0] = 32'h8000_0000;
    f[2][9] = 32'h7FFF_FFFF;
    result_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fire(f[k]);
      fc_done = 1'b0;
      wait_valid(n);
      e = pop_exp();
      checks++;
      if (n !== 9 || class_idx !== e.idx || max_score !== e.val) begin
        fails++;
        $display("FAIL pattern%0d: lat=%0d idx=%0d max=%h, want lat=9 idx=%0d max=%h",
                 k, n, class_idx, max_score, e.idx, e.val);
      end
      @(negedge clk);
    end
    result_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    frame_t a;
    frame_t b;
    exp_t   e;
    int     n;
    for (int i = 0; i < N; i++) begin
      a[i] = W'(i * 2);
      b[i] = W'(50 - i);
    end
    result_ready = 1'b1;
    fire(a);
    fc_done = 1'b0;
    wait_valid(n);
    e = pop_exp();
    checks++;
    if (class_idx !== e.idx || max_score !== e.val) begin
      fails++;
      $display("FAIL b2b_first: idx=%0d max=%0d, want %0d %0d",
               class_idx, max_score, e.idx, e.val);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_gap: valid=%b busy=%b, want 0 0", result_valid, busy);
    end
    fire(b);
    fc_done = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_recapture: busy=%b, want 1", busy);
    end
    wait_valid(n);
    e = pop_exp();
    checks++;
    if (n !== 9 || class_idx !== e.idx || max_score !== e.val || overrun !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second: lat=%0d idx=%0d max=%0d ovr=%b, want 9 %0d %0d 0",
               n, class_idx, max_score, overrun, e.idx, e.val);
    end
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_stall_overrun;
    frame_t a;
    frame_t b;
    exp_t   e;
    int     n;
    int     v [N] = '{3, 8, 1, 0, 2, 4, 6, 11, 5, 9};
    for (int i = 0; i < N; i++) begin
      a[i] = W'(v[i]);
      b[i] = '0;
    end
    b[2] = 32'd100;
    fire(a);
    fc_done = 1'b0;
    wait_valid(n);
    e = pop_exp();
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        scores  = b;
        fc_done = 1'b1;
      end
      if (c == 8) fc_done = 1'b0;
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b1 || class_idx !== e.idx || max_score !== e.val) begin
        fails++;
        $display("FAIL stall_c%0d: valid=%b idx=%0d max=%0d, want 1 %0d %0d",
                 c, result_valid, class_idx, max_score, e.idx, e.val);
      end
    end
    checks++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set: overrun=%b, want 1", overrun);
    end
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_ready = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b1) begin
      fails++;
      $display("FAIL stall_release: valid=%b busy=%b ovr=%b, want 0 0 1",
               result_valid, busy, overrun);
    end
  endtask

  task automatic test_reset_mid_scan;
    frame_t s;
    exp_t   e;
    int     n;
    for (int i = 0; i < N; i++) s[i] = W'(20 + i);
    fire(s);
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 ||
        class_idx !== '0 || max_score !== '0) begin
      fails++;
      $display("FAIL reset_mid: valid=%b busy=%b ovr=%b idx=%0d max=%h, want all 0",
               result_valid, busy, overrun, class_idx, max_score);
    end
    void'(sbq.pop_back());
    fc_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) s[i] = W'(i);
    s[6] = 32'd77;
    fire(s);
    fc_done = 1'b0;
    wait_valid(n);
    e = pop_exp();
    checks++;
    if (n !== 9 || class_idx !== e.idx || max_score !== e.val) begin
      fails++;
      $display("FAIL reset_recover: lat=%0d idx=%0d max=%0d, want 9 %0d %0d",
               n, class_idx, max_score, e.idx, e.val);
    end
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_reset_release_high;
    frame_t s;
    exp_t   e;
    int     n;
    int     extra;
    for (int i = 0; i < N; i++) s[i] = W'(i);
    s[4] = 32'd1000;
    scores  = s;
    fc_done = 1'b1;
    reset   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sbq.push_back(model(s));
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL release_capture: busy=%b, want 1", busy);
    end
    wait_valid(n);
    e = pop_exp();
    checks++;
    if (n !== 9 || class_idx !== e.idx || max_score !== e.val) begin
      fails++;
      $display("FAIL release_result: lat=%0d idx=%0d max=%0d, want 9 %0d %0d",
               n, class_idx, max_score, e.idx, e.val);
    end
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || result_valid !== 1'b0) extra++;
    end
    checks++;
    if (extra !== 0) begin
      fails++;
      $display("FAIL level_no_recapture: busy/valid high %0d cycles, want 0", extra);
    end
    fc_done      = 1'b0;
    result_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_back_to_back();
    test_stall_overrun();
    test_reset_mid_scan();
    test_reset_release_high();
    checks++;
    if (sbq.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d left, want 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fc_argmax.md
# fc_argmax

Classification output stage directly downstream of the fully connected layer. It captures the 10 class scores when the FC stage signals completion, then scans them sequentially to find the highest score. The resulting digit index and score are held behind a valid/ready handshake for the E203-side register interface or any other consumer. One score is compared per clock, which keeps the comparator area to a single signed 32-bit compare.

## Interface
Parameters:
- `NUM_CLASSES`, 10, number of class scores; must be ≥ 2.
- `SCORE_W`, 32, width of each score, two's-complement signed.
- `IDX_W`, 4, width of the class index; must satisfy 2^IDX_W ≥ NUM_CLASSES.

Ports:
- `clk`  in  1  single clock; every register is on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `fc_done`  in  1  FC completion level; stays high until the FC stage is reset.
- `scores`  in  `[NUM_CLASSES-1:0]` × `SCORE_W`  FC output array; stable while `fc_done` is high.
- `result_valid`  out  1  result held and available.
- `result_ready`  in  1  consumer accepts the result.
- `class_idx`  out  `IDX_W`  index of the maximum score.
- `max_score`  out  `SCORE_W`  value of the maximum score.
- `busy`  out  1  high in SCAN or HOLD.
- `overrun`  out  1  sticky flag: an `fc_done` rising edge arrived while busy.

## Operation
- Rising-edge detect: an internal `fc_done_q` register resets to 0. An event is `fc_done && !fc_done_q`.
  - If `fc_done` is already high when reset releases, that counts as one event.
- States: IDLE, SCAN, HOLD.
- IDLE, on an event:
  - latch all `scores` into an internal bank;
  - set `best_val` to score[0], `best_idx` to 0, `cnt` to 1;
  - go to SCAN.
- SCAN, each cycle:
  - signed compare of bank[`cnt`] against `best_val`;
  - update best only on strict greater-than, so ties resolve to the lowest index;
  - increment `cnt`.
  - When `cnt == NUM_CLASSES-1`: apply the final compare, write the result directly into `class_idx`/`max_score`, set `result_valid`, and go to HOLD.
- HOLD:
  - `class_idx`, `max_score` and `result_valid` are frozen.
  - On a clock edge where `result_valid && result_ready`, clear `result_valid` and go to IDLE.
  - `class_idx` and `max_score` keep their last values until the next result is written.
- Overrun: an event seen in SCAN or HOLD is ignored (no recapture) and sets `overrun`. Only `reset` clears `overrun`.
- Arithmetic: comparisons use `$signed` over the full `SCORE_W`, with no truncation. Score 32'h8000_0000 is the most negative value.

## Timing
- Reset values:
  - `result_valid`, `busy`, `overrun` = 0;
  - `class_idx` = 0, `max_score` = 0;
  - state = IDLE.
- Capture edge E: the edge at which IDLE samples the event. `busy` is high from E.
- Latency: `result_valid` rises at edge E+(NUM_CLASSES-1), i.e. E+9 by default.
- Handshake: `result_ready` may be high before valid; the transfer occurs at the first edge where both are high. `result_valid` is low the cycle after the transfer, and `busy` is low at the same time.
- Back-to-back: the earliest next capture is the edge after the transfer edge, and it still requires a fresh rising edge of `fc_done`.
- `scores` are sampled only at E. Changes after E do not affect the result.
- Reset mid-SCAN or mid-HOLD: everything returns to the reset values immediately (asynchronously), and any partial result is discarded.

## Structure
- Shared package `cnn_pkg`:
  - `NUM_CLASSES` and `SCORE_W` constants, shared with the FC layer;
  - `argmax_state_t` enum {IDLE, SCAN, HOLD};
  - `score_t` typedef (`logic signed [SCORE_W-1:0]`).
- One sub-module, `score_cmp`: combinational signed strict-greater compare that outputs the updated best value and best index. It is reusable by later pooling stages.

## Test plan
- Scores {5,1,2,3,4,9,0,7,8,6} with a `fc_done` rise at E → `class_idx`=5, `max_score`=9, `result_valid` high at E+9, `busy` high from E through the transfer.
- All scores -100 except score[3]=-1 → `class_idx`=3, `max_score`=32'hFFFF_FFFF. Ties {7,7,...} → `class_idx`=0.
- Score[9]=32'h7FFF_FFFF and score[0]=32'h8000_0000 → `class_idx`=9. This checks signed compare at the extremes.
- `result_ready` held low for 20 cycles → result frozen; a second `fc_done` toggle meanwhile sets `overrun`=1 and does not change `class_idx`. Then raise `result_ready` → valid drops the next cycle.
- `reset` asserted at E+4 → all outputs read 0 immediately, with no `result_valid`. A new `fc_done` rise after release → correct result 9 edges later.
- `fc_done` high while `reset` deasserts → exactly one capture; `fc_done` staying high afterwards triggers no further captures.
